// File: rtl/muxreg_hs.sv
// NCH:1 load-muxed output register with valid/ready backpressure and explicit or round-robin select.
// Define MUXREG_PARITY_EN to add the registered q_par output (even parity of q).
module muxreg_hs #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NCH   = 8,
   parameter int unsigned SELW  = 3
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic [NCH*WIDTH-1:0]   d,
   input  logic                   load,
   output logic                   load_ready,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   output logic [WIDTH-1:0]       q,
   output logic [SELW-1:0]        q_ch,
   output logic                   q_valid,
   input  logic                   q_ready,
   output logic [SELW-1:0]        rr_ptr,
`ifdef MUXREG_PARITY_EN
   output logic                   q_par,
`endif
   output logic                   sel_err
);

   localparam int unsigned LAST_CH = NCH - 1;

   logic [WIDTH-1:0] r_q;
   logic [SELW-1:0]  r_q_ch;
   logic             r_q_valid;
   logic [SELW-1:0]  r_rr_ptr;
   logic             r_sel_err;

   logic             w_load_ready;
   logic             w_sel_ok;
   logic             w_acc;
   logic             w_bad_sel;
   logic [SELW-1:0]  w_ch;
   logic [WIDTH-1:0] w_data;
   logic [SELW-1:0]  w_rr_next;

   // Accept/select decode; the data mux only covers real channels so an
   // out-of-range index can never reach past the top of d.
   always_comb begin
      w_load_ready = !r_q_valid || q_ready;
      w_sel_ok     = (32'(sel) < NCH);
      w_acc        = load && w_load_ready && (mode || w_sel_ok);
      w_bad_sel    = load && w_load_ready && !mode && !w_sel_ok;
      w_ch         = mode ? r_rr_ptr : sel;
      w_data       = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (w_ch == SELW'(k)) w_data = d[k*WIDTH +: WIDTH];
      end
      w_rr_next    = (r_rr_ptr == SELW'(LAST_CH)) ? '0 : r_rr_ptr + SELW'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         r_q       <= '0;
         r_q_ch    <= '0;
         r_q_valid <= 1'b0;
         r_rr_ptr  <= '0;
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= w_bad_sel;
         if (w_acc) begin
            r_q       <= w_data;
            r_q_ch    <= w_ch;
            r_q_valid <= 1'b1;
            if (mode) r_rr_ptr <= w_rr_next;
         end else if (r_q_valid && q_ready) begin
            r_q_valid <= 1'b0;
         end
      end
   end

`ifdef MUXREG_PARITY_EN
   logic r_q_par;

   always_ff @(posedge CLK) begin
      if (!RSTN)      r_q_par <= 1'b0;
      else if (w_acc) r_q_par <= ^w_data;
   end

   assign q_par = r_q_par;
`endif

   assign load_ready = w_load_ready;
   assign q          = r_q;
   assign q_ch       = r_q_ch;
   assign q_valid    = r_q_valid;
   assign rr_ptr     = r_rr_ptr;
   assign sel_err    = r_sel_err;

endmodule

// File: tb/tb_muxreg_hs.sv
// Directed-vector bench for muxreg_hs (WIDTH=16, NCH=6); parity checks only when MUXREG_PARITY_EN is defined.
module tb_muxreg_hs;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned NCH   = 6;
   localparam int unsigned SELW  = 3;

   logic                 CLK = 1'b0;
   logic                 RSTN;
   logic [NCH*WIDTH-1:0] d;
   logic                 load;
   logic                 load_ready;
   logic                 mode;
   logic [SELW-1:0]      sel;
   logic [WIDTH-1:0]     q;
   logic [SELW-1:0]      q_ch;
   logic                 q_valid;
   logic                 q_ready;
   logic [SELW-1:0]      rr_ptr;
   logic                 sel_err;
`ifdef MUXREG_PARITY_EN
   logic                 q_par;
`endif

   muxreg_hs #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) u_dut (
      .CLK        (CLK),
      .RSTN       (RSTN),
      .d          (d),
      .load       (load),
      .load_ready (load_ready),
      .mode       (mode),
      .sel        (sel),
      .q          (q),
      .q_ch       (q_ch),
      .q_valid    (q_valid),
      .q_ready    (q_ready),
      .rr_ptr     (rr_ptr),
`ifdef MUXREG_PARITY_EN
      .q_par      (q_par),
`endif
      .sel_err    (sel_err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        load;
      logic        mode;
      logic [2:0]  sel;
      logic        qr;
      logic        lr;
      logic [15:0] q;
      logic [2:0]  ch;
      logic        v;
      logic [2:0]  rr;
      logic        err;
   } vec_t;

   localparam int NVEC = 21;
   vec_t vecs [NVEC];

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic chk_regs(input string tag, input logic [15:0] eq, input logic [2:0] ech,
                           input logic ev, input logic [2:0] err_rr, input logic eerr);
      chk({tag, ".q"},       32'(q),       32'(eq));
      chk({tag, ".q_ch"},    32'(q_ch),    32'(ech));
      chk({tag, ".q_valid"}, 32'(q_valid), 32'(ev));
      chk({tag, ".rr_ptr"},  32'(rr_ptr),  32'(err_rr));
      chk({tag, ".sel_err"}, 32'(sel_err), 32'(eerr));
   endtask

   task automatic set_default_d();
      for (int k = 0; k < int'(NCH); k++) d[k*WIDTH +: WIDTH] = 16'hA000 + 16'(k);
   endtask

   initial begin
      // load mode sel qr | lr q ch v rr err  (state after the edge)
      vecs[0]  = '{1'b1, 1'b0, 3'd5, 1'b1, 1'b1, 16'hA005, 3'd5, 1'b1, 3'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA000, 3'd0, 1'b1, 3'd1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA001, 3'd1, 1'b1, 3'd2, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA002, 3'd2, 1'b1, 3'd3, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA003, 3'd3, 1'b1, 3'd4, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA004, 3'd4, 1'b1, 3'd5, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA005, 3'd5, 1'b1, 3'd0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 3'd0, 1'b1, 1'b1, 16'hA000, 3'd0, 1'b1, 3'd1, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 16'hA000, 3'd0, 1'b0, 3'd1, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 3'd7, 1'b0, 1'b1, 16'hA000, 3'd0, 1'b0, 3'd1, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'hA000, 3'd0, 1'b0, 3'd1, 1'b0};
      vecs[11] = '{1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 16'hA002, 3'd2, 1'b1, 3'd1, 1'b0};
      vecs[12] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 16'hA002, 3'd2, 1'b1, 3'd1, 1'b0};
      vecs[13] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 16'hA002, 3'd2, 1'b1, 3'd1, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 3'd4, 1'b0, 1'b0, 16'hA002, 3'd2, 1'b1, 3'd1, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 16'hA004, 3'd4, 1'b1, 3'd1, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 16'hA001, 3'd1, 1'b1, 3'd2, 1'b0};
      vecs[17] = '{1'b1, 1'b0, 3'd6, 1'b1, 1'b1, 16'hA001, 3'd1, 1'b0, 3'd2, 1'b1};
      vecs[18] = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 16'hA001, 3'd1, 1'b0, 3'd2, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 16'hA002, 3'd2, 1'b1, 3'd3, 1'b0};
      vecs[20] = '{1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 16'hA002, 3'd2, 1'b1, 3'd3, 1'b0};

      set_default_d();
      RSTN = 1'b0; load = 1'b1; mode = 1'b1; sel = 3'd0; q_ready = 1'b1;

      // Reset with a pending round-robin load: nothing captured
      repeat (2) @(posedge CLK);
      #1 chk_regs("reset", 16'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
      @(negedge CLK);
      RSTN = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         load = vecs[i].load; mode = vecs[i].mode; sel = vecs[i].sel; q_ready = vecs[i].qr;
         #1 chk($sformatf("v%0d.load_ready", i), 32'(load_ready), 32'(vecs[i].lr));
         @(posedge CLK);
         #1 chk_regs($sformatf("v%0d", i), vecs[i].q, vecs[i].ch, vecs[i].v, vecs[i].rr, vecs[i].err);
         @(negedge CLK);
      end

      // d changes while q is held must not leak into q
      load = 1'b0; q_ready = 1'b0;
      for (int k = 0; k < int'(NCH); k++) d[k*WIDTH +: WIDTH] = 16'h5555;
      @(posedge CLK);
      #1 chk_regs("dhold", 16'hA002, 3'd2, 1'b1, 3'd3, 1'b0);
      @(negedge CLK);
      set_default_d();

      // Mid-stream reset overrides a valid explicit load
      RSTN = 1'b0; load = 1'b1; mode = 1'b0; sel = 3'd3; q_ready = 1'b1;
      @(posedge CLK);
      #1 chk_regs("rst2", 16'h0000, 3'd0, 1'b0, 3'd0, 1'b0);
      @(negedge CLK);
      RSTN = 1'b1;

`ifdef MUXREG_PARITY_EN
      chk("par.reset", 32'(q_par), 32'd0);
      d[0*WIDTH +: WIDTH] = 16'h0007;
      d[1*WIDTH +: WIDTH] = 16'h0003;
      load = 1'b1; mode = 1'b0; sel = 3'd0; q_ready = 1'b1;
      @(posedge CLK);
      #1 chk("par.odd", 32'(q_par), 32'd1);
      chk("par.q0", 32'(q), 32'h0007);
      @(negedge CLK);
      sel = 3'd1;
      @(posedge CLK);
      #1 chk("par.even", 32'(q_par), 32'd0);
      chk("par.q1", 32'(q), 32'h0003);
      @(negedge CLK);
      load = 1'b0; q_ready = 1'b0;
      d[1*WIDTH +: WIDTH] = 16'h0001;
      @(posedge CLK);
      #1 chk("par.hold", 32'(q_par), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
